// File: rtl/proc_pkg.sv
// Shared processor package: boot-loader state type and imem geometry constants.
package proc_pkg;

  localparam int IMEM_ADDR_WIDTH = 8;
  localparam int INSTR_WIDTH     = 32;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_LOAD,
    BOOT_CHECK,
    BOOT_RELEASE,
    BOOT_RUN,
    BOOT_ERROR
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: streams an image into instruction memory, then releases the
// core from reset after a short delay. Define IMEM_BOOT_CHECKSUM_EN to make
// the loader expect one trailing checksum word (sum of all image words) and
// refuse to release the core when it does not match.
module imem_boot_loader
  import proc_pkg::*;
#(
  parameter int ADDR_WIDTH    = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = INSTR_WIDTH,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_resetn,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          REL_LOAD = 4'(RELEASE_DELAY);

  boot_state_e         state;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] wc;
  logic [ADDR_WIDTH:0] count_inc;
  logic [3:0]          rel_cnt;
  logic                hs;
  logic                last_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
`endif

  // Handshake and end-of-image detection for the current stream beat.
  always_comb begin
    hs        = s_valid & s_ready;
    count_inc = count + ONE;
    last_word = (count_inc == wc);
  end

  // Boot FSM with registered outputs; start is honoured only in IDLE, RUN and ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT_IDLE;
      count       <= '0;
      wc          <= '0;
      rel_cnt     <= '0;
      s_ready     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_resetn <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      if (start && (state == BOOT_IDLE || state == BOOT_RUN || state == BOOT_ERROR)) begin
        core_resetn <= 1'b0;
        count       <= '0;
        wc          <= word_count;
        rel_cnt     <= REL_LOAD;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum         <= '0;
`endif
        if (word_count == '0) begin
          state   <= BOOT_RELEASE;
          busy    <= 1'b1;
          error   <= 1'b0;
          s_ready <= 1'b0;
        end else if (word_count > DEPTH) begin
          state   <= BOOT_ERROR;
          busy    <= 1'b0;
          error   <= 1'b1;
          s_ready <= 1'b0;
        end else begin
          state   <= BOOT_LOAD;
          busy    <= 1'b1;
          error   <= 1'b0;
          s_ready <= 1'b1;
        end
      end else begin
        case (state)
          BOOT_LOAD: begin
            if (hs) begin
              imem_we    <= 1'b1;
              imem_addr  <= count[ADDR_WIDTH-1:0];
              imem_wdata <= s_data;
              count      <= count_inc;
`ifdef IMEM_BOOT_CHECKSUM_EN
              sum        <= sum + s_data;
              if (last_word) begin
                state <= BOOT_CHECK;
              end
`else
              if (last_word) begin
                s_ready <= 1'b0;
                state   <= BOOT_RELEASE;
                rel_cnt <= REL_LOAD;
              end
`endif
            end
          end
`ifdef IMEM_BOOT_CHECKSUM_EN
          BOOT_CHECK: begin
            if (hs) begin
              s_ready <= 1'b0;
              if (s_data == sum) begin
                state   <= BOOT_RELEASE;
                rel_cnt <= REL_LOAD;
              end else begin
                state <= BOOT_ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
`endif
          BOOT_RELEASE: begin
            // Leaving on the count of one makes the core see reset exactly
            // RELEASE_DELAY cycles after the last write.
            if (rel_cnt <= 4'd1) begin
              state       <= BOOT_RUN;
              core_resetn <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed/randomized bench for imem_boot_loader with a write-log monitor
// and an image-based reference of the expected imem contents and timing.
module tb_imem_boot_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD = 4;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam int CSW = 1;
`else
  localparam int CSW = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_resetn;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [AW-1:0] w_addr[$];
  logic [DW-1:0] w_data[$];
  int            w_cyc[$];
  int            done_cnt = 0;
  int            rise_cyc = -1;
  logic          prev_rn  = 1'b0;

  logic [DW-1:0] img [0:299];
  int            n_img;
  bit            cs_bad;
  int            last_hs_cyc;
  int            start_cyc;

  imem_boot_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .word_count(word_count),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_resetn(core_resetn),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done/release log, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      w_addr.push_back(imem_addr);
      w_data.push_back(imem_wdata);
      w_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (core_resetn === 1'b1 && prev_rn !== 1'b1) rise_cyc = cyc;
    prev_rn = core_resetn;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int i);
    logic [DW-1:0] s;
    if (i < n_img) return img[i];
    s = '0;
    for (int k = 0; k < n_img; k++) s = s + img[k];
    return s + (cs_bad ? 32'd1 : 32'd0);
  endfunction

  task automatic do_start(input int wc);
    step();
    start      = 1'b1;
    word_count = wc[AW:0];
    step();
    start      = 1'b0;
    start_cyc  = cyc;
  endtask

  // mode 0: continuous valid, 1: valid toggles 1,0,1,0, 2: random gaps
  task automatic send(input int first, input int stop, input int mode);
    int idx;
    int p;
    int guard;
    bit v;
    idx = first;
    p = 0;
    guard = 0;
    while (idx < stop && guard < 5000) begin
      step();
      case (mode)
        0:       v = 1'b1;
        1:       v = (p % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      p++;
      s_valid = v;
      s_data  = v ? word_at(idx) : $urandom;
      if (v && s_ready === 1'b1) begin
        idx++;
        last_hs_cyc = cyc + 1;
      end
      guard++;
    end
    if (idx < stop) chk("stream_timeout", idx, stop);
    step();
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int g;
    g = 0;
    while (done_cnt == base && g < 200) begin
      step();
      g++;
    end
    chk(tag, done_cnt > base, 1);
  endtask

  task automatic check_image(input int base, input int n, input string tag);
    int mism;
    mism = 0;
    chk({tag, "_nwrites"}, w_addr.size() - base, n);
    for (int i = 0; i < n && base + i < w_addr.size(); i++)
      if (w_addr[base + i] !== i[AW-1:0] || w_data[base + i] !== img[i]) mism++;
    chk({tag, "_contents"}, mism, 0);
  endtask

  task automatic rand_image(input int n);
    n_img = n;
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask

  task automatic full_load(input int n, input int mode, input string tag);
    int b;
    int bd;
    rand_image(n);
    b  = w_addr.size();
    bd = done_cnt;
    do_start(n);
    chk({tag, "_resetn_low"}, core_resetn, 0);
    send(0, n + CSW, mode);
    check_image(b, n, tag);
    wait_done(bd, {tag, "_done"});
    step();
    step();
    chk({tag, "_release"}, rise_cyc - last_hs_cyc, RD);
    chk({tag, "_done_once"}, done_cnt - bd, 1);
  endtask

  initial begin
    int b;
    int bd;
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    cs_bad     = 1'b0;
    n_img      = 0;
    step();
    step();
    chk("rst_core_resetn", core_resetn, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    step();
    step();
    chk("idle_core_resetn", core_resetn, 0);

    // Three-word program, continuous valid
    n_img  = 3;
    img[0] = 32'h01908093;
    img[1] = 32'h04b10113;
    img[2] = 32'h002080b3;
    b  = w_addr.size();
    bd = done_cnt;
    do_start(3);
    chk("t1_busy", busy, 1);
    chk("t1_s_ready", s_ready, 1);
    send(0, 3 + CSW, 0);
    check_image(b, 3, "t1");
`ifndef IMEM_BOOT_CHECKSUM_EN
    chk("t1_back_to_back", w_cyc[b + 2] - w_cyc[b], 2);
`endif
    wait_done(bd, "t1_done");
    step();
    step();
`ifndef IMEM_BOOT_CHECKSUM_EN
    chk("t1_we_to_resetn", rise_cyc - w_cyc[b + 2], RD);
`endif
    chk("t1_release", rise_cyc - last_hs_cyc, RD);
    chk("t1_done_once", done_cnt - bd, 1);
    chk("t1_run_resetn", core_resetn, 1);
    chk("t1_run_busy", busy, 0);
    chk("t1_run_s_ready", s_ready, 0);

    // Same image from RUN with valid toggling
    b  = w_addr.size();
    bd = done_cnt;
    do_start(3);
    chk("t2_resetn_low", core_resetn, 0);
    send(0, 3 + CSW, 1);
    chk("t2_s_ready_drop", s_ready, 0);
    check_image(b, 3, "t2");
`ifndef IMEM_BOOT_CHECKSUM_EN
    chk("t2_gap", w_cyc[b + 1] - w_cyc[b], 2);
`endif
    wait_done(bd, "t2_done");
    step();
    step();
    chk("t2_release", rise_cyc - last_hs_cyc, RD);

    // Reload of two words from RUN
    full_load(2, 2, "t2b");

    // Empty image
    b  = w_addr.size();
    bd = done_cnt;
    do_start(0);
    chk("t3_busy", busy, 1);
    chk("t3_s_ready", s_ready, 0);
    wait_done(bd, "t3_done");
    step();
    step();
    chk("t3_release", rise_cyc - start_cyc, RD);
    chk("t3_no_writes", w_addr.size() - b, 0);
    chk("t3_run_resetn", core_resetn, 1);

    // Oversized image
    b = w_addr.size();
    do_start(257);
    step();
    step();
    step();
    chk("t4_error", error, 1);
    chk("t4_core_resetn", core_resetn, 0);
    chk("t4_busy", busy, 0);
    chk("t4_s_ready", s_ready, 0);
    chk("t4_no_writes", w_addr.size() - b, 0);

    // Reset after two of five words, then a clean reload
    rand_image(5);
    do_start(5);
    chk("t5_error_clear", error, 0);
    send(0, 2, 0);
    chk("t5_we_before_reset", imem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_imem_we", imem_we, 0);
    chk("t5_rst_imem_addr", imem_addr, 0);
    chk("t5_rst_imem_wdata", imem_wdata, 0);
    chk("t5_rst_s_ready", s_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_core_resetn", core_resetn, 0);
    chk("t5_rst_error", error, 0);
    step();
    reset = 1'b0;
    step();
    full_load(5, 2, "t5");

    // start pulse during LOAD must be ignored
    rand_image(4);
    b  = w_addr.size();
    bd = done_cnt;
    do_start(4);
    send(0, 2, 2);
    step();
    start      = 1'b1;
    word_count = 9'd1;
    step();
    start = 1'b0;
    chk("t6_still_loading", s_ready, 1);
    send(2, 4 + CSW, 2);
    check_image(b, 4, "t6");
    wait_done(bd, "t6_done");

    // Full-depth image
    b = w_addr.size();
    full_load(256, 2, "t7");
    chk("t7_last_addr", w_addr[w_addr.size() - 1], 8'hff);

    // Random images
    for (int it = 0; it < 4; it++) full_load($urandom_range(1, 24), $urandom_range(0, 2), "t8");

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum accept and reject
    n_img  = 2;
    img[0] = 32'h1;
    img[1] = 32'h2;
    cs_bad = 1'b0;
    bd = done_cnt;
    do_start(2);
    send(0, 3, 0);
    wait_done(bd, "t9_done");
    step();
    chk("t9_run_resetn", core_resetn, 1);
    cs_bad = 1'b1;
    bd = done_cnt;
    do_start(2);
    send(0, 3, 0);
    for (int g = 0; g < 20 && error !== 1'b1; g++) step();
    step();
    step();
    step();
    step();
    step();
    chk("t9_error", error, 1);
    chk("t9_core_resetn", core_resetn, 0);
    chk("t9_no_done", done_cnt - bd, 0);
    cs_bad = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
